// File: rtl/lz4_stream_decoder.sv
// LZ4 block decoder: consumes a compressed byte stream, emits decompressed bytes.
// Matches are copied from a 2^HIST_AW byte history ring that is read combinationally,
// so overlapping matches (offset < length) replay bytes written on earlier cycles.
// HIST_AW must not exceed 16 (offsets are 16-bit).
module lz4_stream_decoder #(
  parameter int HIST_AW = 12,
  parameter int LEN_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done,
  output logic       error
);

  typedef enum logic [3:0] {
    TOKEN, LIT_EXT, LITERAL, OFF_LO, OFF_HI, MAT_EXT, COPY, DONE, ERR
  } state_t;

  localparam logic [HIST_AW:0] PROD_MAX = {1'b1, {HIST_AW{1'b0}}};

  state_t             state;
  logic [7:0]         hist [0:(1<<HIST_AW)-1];
  logic [HIST_AW-1:0] wr_ptr;
  logic [HIST_AW:0]   produced;
  logic [LEN_W-1:0]   lit_len, mat_len;
  logic [HIST_AW-1:0] offset;
  logic [7:0]         off_lo;
  logic [3:0]         tok_mat;
  // block has ended; waiting for the output register to drain before DONE
  logic               fin;

  logic               out_free, xfer, adv, err_now, off_bad;
  logic [7:0]         copy_byte, hist_wd;
  logic [15:0]        off16;
  logic [LEN_W:0]     lit_sum, mat_sum;

  assign out_free  = !out_valid || out_ready;
  assign xfer      = in_valid && in_ready;
  assign copy_byte = hist[wr_ptr - offset];
  assign off16     = {in_data, off_lo};
  assign lit_sum   = {1'b0, lit_len} + (LEN_W+1)'(in_data);
  assign mat_sum   = {1'b0, mat_len} + (LEN_W+1)'(in_data);
  assign off_bad   = (off16 == 16'd0) || (32'(off16) > 32'(produced)) ||
                     (32'(off16) > ((32'd1 << HIST_AW) - 32'd1));
  // a byte enters the output register (and history) this cycle
  assign adv       = !reset && ((state == LITERAL && xfer) || (state == COPY && out_free));
  assign hist_wd   = (state == LITERAL) ? in_data : copy_byte;

  // input acceptance: header/offset states always, literals only when the output slot frees
  always_comb begin
    in_ready = 1'b0;
    if (!reset && !fin) begin
      case (state)
        TOKEN, LIT_EXT, OFF_LO, OFF_HI, MAT_EXT: in_ready = 1'b1;
        LITERAL: in_ready = out_free;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // format violations detected on the byte being transferred
  always_comb begin
    err_now = 1'b0;
    case (state)
      TOKEN:   err_now = in_last && (in_data[7:4] != 4'd0);
      LIT_EXT: err_now = in_last || lit_sum[LEN_W];
      LITERAL: err_now = in_last && (lit_len != LEN_W'(1));
      OFF_LO:  err_now = in_last;
      OFF_HI:  err_now = in_last || off_bad;
      MAT_EXT: err_now = in_last || mat_sum[LEN_W];
      default: err_now = 1'b0;
    endcase
    err_now = err_now && xfer;
  end

  // history ring write; contents are not reset
  always_ff @(posedge clk) begin
    if (adv) hist[wr_ptr] <= hist_wd;
  end

  // decode FSM and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TOKEN;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      done      <= 1'b0;
      error     <= 1'b0;
      wr_ptr    <= '0;
      produced  <= '0;
      lit_len   <= '0;
      mat_len   <= '0;
      offset    <= '0;
      off_lo    <= 8'd0;
      tok_mat   <= 4'd0;
      fin       <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (adv) begin
        out_data  <= hist_wd;
        out_valid <= 1'b1;
        wr_ptr    <= wr_ptr + HIST_AW'(1);
        if (produced != PROD_MAX) produced <= produced + (HIST_AW+1)'(1);
      end
      case (state)
        TOKEN: if (xfer) begin
          lit_len <= LEN_W'(in_data[7:4]);
          mat_len <= LEN_W'(in_data[3:0]) + LEN_W'(4);
          tok_mat <= in_data[3:0];
          if (in_data[7:4] == 4'd0 && in_last) fin <= 1'b1;
          else if (in_data[7:4] == 4'd15)     state <= LIT_EXT;
          else if (in_data[7:4] != 4'd0)      state <= LITERAL;
          else                                state <= OFF_LO;
        end
        LIT_EXT: if (xfer) begin
          lit_len <= lit_sum[LEN_W-1:0];
          if (in_data != 8'hFF) state <= LITERAL;
        end
        LITERAL: if (xfer) begin
          lit_len <= lit_len - LEN_W'(1);
          if (lit_len == LEN_W'(1)) begin
            if (in_last) fin <= 1'b1;
            else         state <= OFF_LO;
          end
        end
        OFF_LO: if (xfer) begin
          off_lo <= in_data;
          state  <= OFF_HI;
        end
        OFF_HI: if (xfer) begin
          offset <= HIST_AW'(off16);
          state  <= (tok_mat == 4'd15) ? MAT_EXT : COPY;
        end
        MAT_EXT: if (xfer) begin
          mat_len <= mat_sum[LEN_W-1:0];
          if (in_data != 8'hFF) state <= COPY;
        end
        COPY: if (out_free) begin
          mat_len <= mat_len - LEN_W'(1);
          if (mat_len == LEN_W'(1)) state <= TOKEN;
        end
        default: ;
      endcase
      if (fin && out_free) begin
        state     <= DONE;
        done      <= 1'b1;
        out_valid <= 1'b0;
        fin       <= 1'b0;
      end
      if (err_now) begin
        state     <= ERR;
        error     <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lz4_stream_decoder.md
LZ4_STREAM_DECODER -- requirements
Module: lz4_stream_decoder

Interface
REQ-001 SHALL have parameter HIST_AW, default 12, meaning the history window is 2^HIST_AW bytes.
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the literal and match length counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8, the compressed byte.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-007 SHALL have port in_last, input, 1, marking the final byte of the compressed block.
REQ-008 SHALL have port in_ready, output, 1; an input byte transfers on cycles where in_valid and in_ready are both high.
REQ-009 SHALL have port out_data, output, 8, the decompressed byte.
REQ-010 SHALL have port out_valid, output, 1; an output byte transfers on cycles where out_valid and out_ready are both high.
REQ-011 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-012 SHALL have port done, output, 1, which stays high after the block is decoded and the last byte has transferred.
REQ-013 SHALL have port error, output, 1, which stays high after a format violation is detected.

Function
REQ-014 SHALL use the FSM states TOKEN, LIT_EXT, LITERAL, OFF_LO, OFF_HI, MAT_EXT, COPY, DONE and ERR.
REQ-015 SHALL, in TOKEN, consume one byte and set lit_len to token[7:4] and mat_len to token[3:0]+4.
REQ-016 SHALL go from TOKEN to LIT_EXT if token[7:4]==15, otherwise to LITERAL if lit_len>0, otherwise to OFF_LO.
REQ-017 SHALL, in LIT_EXT, add each byte to lit_len and leave LIT_EXT on the first byte that is not 255; the same rule applies to MAT_EXT and mat_len when token[3:0]==15.
REQ-018 SHALL, in LITERAL, pass each input byte to the output register, write it to history, and decrement lit_len, going to OFF_LO when lit_len reaches 0.
REQ-019 SHALL end the block when in_last is transferred on the final literal, or on a token with token[7:4]==0: go to DONE once the output register drains.
REQ-020 SHALL take the offset as a 16-bit little-endian value, low byte in OFF_LO and high byte in OFF_HI.
REQ-021 SHALL go to MAT_EXT or COPY after OFF_HI, as selected by token[3:0].
REQ-022 SHALL, in COPY, output one byte per cycle from history[wr_ptr-offset] and write that byte at wr_ptr.
REQ-023 SHALL read history combinationally, so overlapping matches (offset<mat_len, including offset=1 run-length) reproduce correctly.
REQ-024 SHALL go from COPY to TOKEN after mat_len bytes have been output.
REQ-025 SHALL hold in_ready low during COPY.
REQ-026 SHALL hold the output register whenever out_valid=1 and out_ready=0.
REQ-027 SHALL drive in_ready = (state in {TOKEN, LIT_EXT, OFF_LO, OFF_HI, MAT_EXT}) or (state==LITERAL and (!out_valid or out_ready)).
REQ-028 SHALL sustain one byte per cycle throughput in LITERAL and COPY when out_ready is held high.
REQ-029 SHALL give a first-byte latency of 1 cycle from a literal input transfer to out_valid.
REQ-030 SHALL keep wr_ptr at HIST_AW bits, wrapping modulo 2^HIST_AW.
REQ-031 SHALL keep a produced-byte count that saturates at 2^HIST_AW.
REQ-032 SHALL go to ERR on offset==0.
REQ-033 SHALL go to ERR on an offset greater than the produced count.
REQ-034 SHALL go to ERR on an offset greater than 2^HIST_AW-1.
REQ-035 SHALL go to ERR on in_last transferred in any state other than those listed in REQ-019.
REQ-036 SHALL go to ERR on a length-counter overflow beyond 2^LEN_W-1.
REQ-037 SHALL, in ERR and DONE, hold in_ready=0 and out_valid=0; only reset exits these states.

Reset
REQ-038 SHALL, on reset, set state=TOKEN, in_ready=0 for that cycle, out_valid=0, out_data=0, done=0, error=0, wr_ptr=0, produced count=0, lit_len=0 and mat_len=0.
REQ-039 SHALL, when reset is asserted mid-block (any state), abort immediately, drop any pending output byte, and start the next cycle awaiting a fresh token.
REQ-040 SHALL leave history contents undefined after reset; they are never read before being rewritten, per REQ-033.

Verification
REQ-041 SHALL be verified with: bytes 0x30,'a','b','c' (last on 'c') -> out "abc", done=1, error=0.
REQ-042 SHALL be verified with: 0x14,'x',0x01,0x00,0x00(token 0x00 last) -> "xxxxxxxxx" (1+8 bytes), covering overlap with offset=1.
REQ-043 SHALL be verified with: token 0xF0, ext 0xFF,0x02, then 272 literals -> 272 bytes out, in order, no error.
REQ-044 SHALL be verified with: 0x10,'a',0x05,0x00 -> error=1 (offset 5 > produced 1), and no further bytes out.
REQ-045 SHALL be verified with: case REQ-042 with out_ready toggling 1/0 randomly -> identical output stream, with out_data stable while stalled.
REQ-046 SHALL be verified with: reset pulsed during COPY -> out_valid=0 next cycle, then REQ-041 decodes correctly.
